bcd_to_binary_converter: RTL

Sequential BCD-to-binary converter: accepts five BCD digits (ten-thousands down to units) and produces the 16-bit unsigned binary value. Uses reverse double-dabble (shift-right / subtract-3), one bit per clock. Sits on the input side of the display/entry path, so keypad- or switch-entered decimal numbers can feed the prime-detection datapath. Flags invalid digits (>9) and values above 65535.

---
 rtl/bcd_to_binary_converter.sv | 112 +++++++++++
 1 files changed

// File: rtl/bcd_to_binary_converter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_to_binary_converter: five BCD digits to 16-bit binary, using     |
// | reverse double-dabble at one bit per clock.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bcd_to_binary_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [3:0]       Digit4,
  input  logic [3:0]       Digit3,
  input  logic [3:0]       Digit2,
  input  logic [3:0]       Digit1,
  input  logic [3:0]       Digit0,
  output logic [WIDTH-1:0] BinaryValue,
  output logic             Valid,
  output logic             Busy,
  output logic             Error
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [BCD_W-1:0] digits_in;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_next;
  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] bin_next;
  logic [CNT_W-1:0] count;
  logic             digit_bad;
  logic             err_flag;

  assign digits_in = {Digit4, Digit3, Digit2, Digit1, Digit0};

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // One reverse double-dabble step; nibbles are corrected independently.
  always_comb begin
    {bcd_next, bin_next} = {bcd_reg, bin_reg} >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_next[4*i +: 4] >= 4'd8) bcd_next[4*i +: 4] = bcd_next[4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      bcd_reg     <= '0;
      bin_reg     <= '0;
      count       <= '0;
      err_flag    <= 1'b0;
      BinaryValue <= '0;
      Valid       <= 1'b0;
      Busy        <= 1'b0;
      Error       <= 1'b0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          // Busy still high here means this is the Valid cycle: Start is ignored.
          if (Start && !Busy) begin
            bcd_reg  <= digits_in;
            bin_reg  <= '0;
            count    <= '0;
            err_flag <= digit_bad;
            Busy     <= 1'b1;
            state    <= digit_bad ? DONE : SHIFT;
          end else begin
            Busy <= 1'b0;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_next;
          count   <= count + 1'b1;
          if (count == LAST_ITER) state <= DONE;
        end
        DONE: begin
          Valid <= 1'b1;
          if (err_flag || (bcd_reg != '0)) begin
            BinaryValue <= '0;
            Error       <= 1'b1;
          end else begin
            BinaryValue <= bin_reg;
            Error       <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
